// File: rtl/timer_counter.sv
// Tick-driven WIDTH-bit up-counter with auto-reload, compare match, one-shot/periodic modes, sticky flags and IRQ.
// Register writes and counting take effect one HCLK after the strobe or tick; irq lags its flag by one cycle. No backpressure.
module timer_counter #(
   parameter int WIDTH = 16
) (
   input  logic             HCLK,
   input  logic             n_RST,
   input  logic             tim_clk,
   input  logic             bypass,
   input  logic             en,
   input  logic             one_shot,
   input  logic             arr_we,
   input  logic [WIDTH-1:0] arr_in,
   input  logic             ccr_we,
   input  logic [WIDTH-1:0] ccr_in,
   input  logic             cnt_we,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             clr_ovf,
   input  logic             clr_cmp,
   input  logic             ovf_ie,
   input  logic             cmp_ie,
   output logic [WIDTH-1:0] count,
   output logic             ovf_flag,
   output logic             cmp_flag,
   output logic             running,
   output logic             irq
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             tim_clk_q;
   logic             tick;
   logic             advance;
   logic             cmp_set;
   logic             ovf_set;
   logic [WIDTH-1:0] arr;
   logic [WIDTH-1:0] ccr;

   // tim_clk is derived from HCLK, so a single sample flop is enough for edge detection
   assign tick    = bypass | (tim_clk & ~tim_clk_q);
   // a counter load in the same cycle suppresses the increment and both flag sets
   assign advance = (state == RUN) & en & tick & ~cnt_we;
   assign cmp_set = advance & (count == ccr);
   assign ovf_set = advance & (count >= arr);

   always_comb begin
      state_nxt = state;
      running   = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = RUN;
         end
         RUN: begin
            running = 1'b1;
            if (!en)
               state_nxt = IDLE;
            else if (ovf_set && one_shot)
               state_nxt = DONE;
         end
         DONE: begin
            if (!en) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge n_RST) begin
      if (!n_RST) begin
         state     <= IDLE;
         tim_clk_q <= 1'b0;
         arr       <= '1;
         ccr       <= '1;
         count     <= '0;
         ovf_flag  <= 1'b0;
         cmp_flag  <= 1'b0;
         irq       <= 1'b0;
      end else begin
         state     <= state_nxt;
         tim_clk_q <= tim_clk;
         if (arr_we) arr <= arr_in;
         if (ccr_we) ccr <= ccr_in;
         if (cnt_we)
            count <= cnt_in;
         else if (advance)
            count <= ovf_set ? '0 : count + {{(WIDTH-1){1'b0}}, 1'b1};
         ovf_flag  <= ovf_set | (ovf_flag & ~clr_ovf);
         cmp_flag  <= cmp_set | (cmp_flag & ~clr_cmp);
         irq       <= (ovf_flag & ovf_ie) | (cmp_flag & cmp_ie);
      end
   end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: bypass and divided ticks, one-shot, compare, priorities, async reset.
module tb_timer_counter;

   localparam int WIDTH = 16;

   logic             HCLK = 1'b0;
   logic             n_RST;
   logic             tim_clk;
   logic             bypass, en, one_shot;
   logic             arr_we, ccr_we, cnt_we;
   logic [WIDTH-1:0] arr_in, ccr_in, cnt_in;
   logic             clr_ovf, clr_cmp, ovf_ie, cmp_ie;
   logic [WIDTH-1:0] count;
   logic             ovf_flag, cmp_flag, running, irq;

   logic [2:0]       div_cnt = 3'd0;
   logic             tim_run = 1'b0;

   int               n_chk = 0;
   int               n_err = 0;

   timer_counter #(.WIDTH(WIDTH)) dut (
      .HCLK     (HCLK),
      .n_RST    (n_RST),
      .tim_clk  (tim_clk),
      .bypass   (bypass),
      .en       (en),
      .one_shot (one_shot),
      .arr_we   (arr_we),
      .arr_in   (arr_in),
      .ccr_we   (ccr_we),
      .ccr_in   (ccr_in),
      .cnt_we   (cnt_we),
      .cnt_in   (cnt_in),
      .clr_ovf  (clr_ovf),
      .clr_cmp  (clr_cmp),
      .ovf_ie   (ovf_ie),
      .cmp_ie   (cmp_ie),
      .count    (count),
      .ovf_flag (ovf_flag),
      .cmp_flag (cmp_flag),
      .running  (running),
      .irq      (irq)
   );

   always #5 HCLK = ~HCLK;

   // divide-by-8 prescaler model: tim_clk high 4 HCLK, low 4 HCLK
   always @(posedge HCLK) begin
      if (!tim_run) div_cnt <= 3'd0;
      else          div_cnt <= div_cnt + 3'd1;
   end
   assign tim_clk = div_cnt[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   int exp1 [5] = '{1, 2, 3, 4, 0};
   int t_chg [3];
   int v_chg [3];
   int f_chg [3];
   int n_chg, cyc;
   logic [WIDTH-1:0] prev;

   initial begin
      n_RST = 1'b0; bypass = 1'b1; en = 1'b0; one_shot = 1'b0;
      arr_we = 1'b0; ccr_we = 1'b0; cnt_we = 1'b0;
      arr_in = '0; ccr_in = '0; cnt_in = '0;
      clr_ovf = 1'b0; clr_cmp = 1'b0; ovf_ie = 1'b0; cmp_ie = 1'b0;
      step(2);
      chk("rst_count", count, 0);
      chk("rst_ovf", ovf_flag, 0);
      chk("rst_cmp", cmp_flag, 0);
      chk("rst_running", running, 0);
      chk("rst_irq", irq, 0);
      n_RST = 1'b1;
      step(1);

      // 1) bypass periodic, arr=4
      arr_we = 1'b1; arr_in = 16'd4; ovf_ie = 1'b1; en = 1'b1;
      step(1);
      arr_we = 1'b0;
      chk("t1_running", running, 1);
      chk("t1_start", count, 0);
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("t1_seq", count, exp1[i]);
         chk("t1_ovf", ovf_flag, (i == 4) ? 1 : 0);
         chk("t1_irq", irq, 0);
      end
      step(1);
      chk("t1_irq_lag", irq, 1);
      chk("t1_cnt_after", count, 1);
      en = 1'b0; clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("t1_hold", count, 1);
      chk("t1_ovf_clr", ovf_flag, 0);
      chk("t1_irq_still", irq, 1);
      step(1);
      chk("t1_irq_drop", irq, 0);
      chk("t1_idle", running, 0);

      // 2) divided tim_clk, arr=2
      cnt_we = 1'b1; cnt_in = '0; arr_we = 1'b1; arr_in = 16'd2; bypass = 1'b0; tim_run = 1'b1;
      step(1);
      cnt_we = 1'b0; arr_we = 1'b0; en = 1'b1;
      prev = count; n_chg = 0; cyc = 0;
      for (int i = 0; i < 60 && n_chg < 3; i++) begin
         step(1);
         cyc++;
         if (count != prev) begin
            t_chg[n_chg] = cyc; v_chg[n_chg] = int'(count); f_chg[n_chg] = int'(ovf_flag);
            n_chg++;
            prev = count;
         end
      end
      chk("t2_nticks", n_chg, 3);
      if (n_chg == 3) begin
         chk("t2_gap1", t_chg[1] - t_chg[0], 8);
         chk("t2_gap2", t_chg[2] - t_chg[1], 8);
         chk("t2_v0", v_chg[0], 1);
         chk("t2_v1", v_chg[1], 2);
         chk("t2_v2", v_chg[2], 0);
         chk("t2_ovf_early", f_chg[1], 0);
         chk("t2_ovf", f_chg[2], 1);
      end
      en = 1'b0; clr_ovf = 1'b1; tim_run = 1'b0;
      step(1);
      clr_ovf = 1'b0; bypass = 1'b1;
      step(1);

      // 3) one-shot, arr=3
      cnt_we = 1'b1; cnt_in = '0; arr_we = 1'b1; arr_in = 16'd3; one_shot = 1'b1;
      step(1);
      cnt_we = 1'b0; arr_we = 1'b0; en = 1'b1;
      step(1);
      step(3);
      chk("t3_peak", count, 3);
      chk("t3_run", running, 1);
      step(1);
      chk("t3_wrap", count, 0);
      chk("t3_done", running, 0);
      chk("t3_ovf", ovf_flag, 1);
      step(3);
      chk("t3_stay", count, 0);
      chk("t3_stay_done", running, 0);
      en = 1'b0;
      step(1);
      en = 1'b1;
      step(1);
      chk("t3_rerun", running, 1);
      step(1);
      chk("t3_restart", count, 1);
      en = 1'b0; one_shot = 1'b0; clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;

      // 4) compare match, ccr=5 arr=9
      cnt_we = 1'b1; cnt_in = '0; arr_we = 1'b1; arr_in = 16'd9;
      ccr_we = 1'b1; ccr_in = 16'd5; cmp_ie = 1'b1;
      step(1);
      cnt_we = 1'b0; arr_we = 1'b0; ccr_we = 1'b0; en = 1'b1;
      step(1);
      step(5);
      chk("t4_at5", count, 5);
      chk("t4_cmp_pre", cmp_flag, 0);
      step(1);
      chk("t4_cmp_set", cmp_flag, 1);
      chk("t4_cnt6", count, 6);
      step(1);
      chk("t4_irq", irq, 1);
      clr_cmp = 1'b1;
      step(1);
      clr_cmp = 1'b0;
      chk("t4_cmp_clr", cmp_flag, 0);
      step(7);
      chk("t4_at5b", count, 5);
      chk("t4_wrap_ovf", ovf_flag, 1);
      clr_cmp = 1'b1;
      step(1);
      clr_cmp = 1'b0;
      chk("t4_set_wins", cmp_flag, 1);
      en = 1'b0; clr_cmp = 1'b1; clr_ovf = 1'b1;
      step(1);
      clr_cmp = 1'b0; clr_ovf = 1'b0;

      // 5) arr below live count, then load vs tick
      cnt_we = 1'b1; cnt_in = 16'd7; arr_we = 1'b1; arr_in = 16'd15;
      ccr_we = 1'b1; ccr_in = '1; bypass = 1'b0;
      step(1);
      cnt_we = 1'b0; arr_we = 1'b0; ccr_we = 1'b0; en = 1'b1;
      step(2);
      chk("t5_held7", count, 7);
      chk("t5_running", running, 1);
      arr_we = 1'b1; arr_in = 16'd3;
      step(1);
      arr_we = 1'b0; bypass = 1'b1;
      step(1);
      chk("t5_wrap", count, 0);
      chk("t5_ovf", ovf_flag, 1);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("t5_ovf_clr", ovf_flag, 0);
      step(2);
      chk("t5_at3", count, 3);
      cnt_we = 1'b1; cnt_in = 16'd2;
      step(1);
      cnt_we = 1'b0;
      chk("t5_load", count, 2);
      chk("t5_no_ovf", ovf_flag, 0);
      step(2);
      chk("t5_ovf2", ovf_flag, 1);
      step(1);
      chk("t5_cnt1", count, 1);
      chk("t5_irq", irq, 1);

      // 6) asynchronous reset mid-count
      #2;
      n_RST = 1'b0;
      #1;
      chk("t6_count", count, 0);
      chk("t6_ovf", ovf_flag, 0);
      chk("t6_cmp", cmp_flag, 0);
      chk("t6_irq", irq, 0);
      chk("t6_running", running, 0);
      step(1);
      n_RST = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
